flash_memory: RTL and testbench



---
 rtl/flash_pkg.sv | 13 +
 rtl/flash_array.sv | 32 +++
 rtl/flash_memory.sv | 117 +++++++++++
 tb/tb_flash_memory.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared constants and types for the byte-wide flash model.
// The optional page-erase feature is enabled by defining FLASH_ERASE_EN.
package flash_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;
  localparam int PAGE_W = 8;
  localparam logic [DATA_W-1:0] ERASED_BYTE = 8'hFF;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] byte_t;

endpackage

// File: rtl/flash_array.sv
// Single-port synchronous byte array with a registered read port.
// Contents start erased and are never touched by reset.
module flash_array
  import flash_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  prog_and,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // NOTE: the storage array has no reset path; its contents must survive
  // reset, and the declaration initialiser models the erased power-up state.
  byte_t mem [DEPTH] = '{default: ERASED_BYTE};

  // One port: a write always wins the cycle, otherwise a read may use it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= prog_and ? (mem[idx] & wdata) : wdata;
    end else if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/flash_memory.sv
// Flash model top: write/read arbitration, two-edge read pipeline and,
// when FLASH_ERASE_EN is defined, a 256-byte page erase sequencer.
module flash_memory
  import flash_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] in,
`ifdef FLASH_ERASE_EN
  input  logic              erase,
  output logic              busy,
`endif
  output logic [DATA_W-1:0] out
);

  logic [DEPTH_LOG2-1:0] idx;
  logic                  arr_we;
  logic                  arr_re;
  logic                  arr_and;
  logic [DEPTH_LOG2-1:0] arr_idx;
  byte_t                 arr_wdata;
  byte_t                 arr_rdata;
  logic                  s1_valid;

  // Upper address bits alias onto the implemented array.
  assign idx = addr[DEPTH_LOG2-1:0];
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[ADDR_W-1:DEPTH_LOG2];

`ifdef FLASH_ERASE_EN
  localparam int PG_W = DEPTH_LOG2 - PAGE_W;

  logic              erase_start;
  logic [PG_W-1:0]   erase_page;
  logic [PAGE_W-1:0] erase_off;

  assign erase_start = erase && !busy;

  // NOTE: every signal driven here gets a default first so no latch can form.
  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_and   = 1'b1;
    arr_idx   = idx;
    arr_wdata = in;
    if (busy) begin
      arr_we    = 1'b1;
      arr_and   = 1'b0;
      arr_idx   = {erase_page, erase_off};
      arr_wdata = ERASED_BYTE;
    end else if (!erase_start) begin
      arr_we = we;
      arr_re = re && !we;
    end
  end
`else
  always_comb begin
    arr_we    = we;
    arr_re    = re && !we;
    arr_and   = 1'b0;
    arr_idx   = idx;
    arr_wdata = in;
  end
`endif

  flash_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .wr_en   (arr_we),
    .rd_en   (arr_re),
    .prog_and(arr_and),
    .idx     (arr_idx),
    .wdata   (arr_wdata),
    .rdata   (arr_rdata)
  );

  // Stage 1 is the array's read register plus this valid bit; E2 moves the
  // captured byte into out, so out only changes on a completed read.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      out      <= '0;
    end else begin
      s1_valid <= arr_re;
      if (s1_valid) begin
        out <= arr_rdata;
      end
    end
  end

`ifdef FLASH_ERASE_EN
  // busy rises on the start edge and falls after the write of offset 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      erase_off  <= '0;
      erase_page <= '0;
    end else if (busy) begin
      erase_off <= erase_off + 1'b1;
      if (erase_off == '1) begin
        busy <= 1'b0;
      end
    end else if (erase_start) begin
      busy       <= 1'b1;
      erase_off  <= '0;
      erase_page <= idx[DEPTH_LOG2-1:PAGE_W];
    end
  end
`endif

endmodule

// File: tb/tb_flash_memory.sv
// Directed table-driven bench for flash_memory plus hand sequences for
// word assembly, reset during a pending read and (FLASH_ERASE_EN) erase.
module tb_flash_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic        re;
  logic [23:0] addr;
  logic [7:0]  in_b;
  logic [7:0]  out;
`ifdef FLASH_ERASE_EN
  logic        erase;
  logic        busy;
`endif

  always #5 clk = ~clk;

  flash_memory #(.DEPTH_LOG2(12)) dut (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .re   (re),
    .addr (addr),
    .in   (in_b),
`ifdef FLASH_ERASE_EN
    .erase(erase),
    .busy (busy),
`endif
    .out  (out)
  );

  typedef struct {
    logic        we;
    logic        re;
    logic [23:0] addr;
    logic [7:0]  din;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
  task automatic step(input logic w, input logic r, input logic [23:0] a, input logic [7:0] d);
    @(negedge clk);
    we = w; re = r; addr = a; in_b = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic w, input logic r, input logic [23:0] a,
                     input logic [7:0] d, input logic [7:0] e);
    vec_t v;
    v.we = w; v.re = r; v.addr = a; v.din = d; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic idle(input logic [7:0] e);
    add(1'b0, 1'b0, 24'hxxxxxx, 8'h00, e);
  endtask

  initial begin
    logic [31:0] word;
`ifdef FLASH_ERASE_EN
    int n;
    erase = 1'b0;
`endif
    reset = 1'b1; we = 1'b0; re = 1'b0; addr = '0; in_b = '0;

    // Program image big-endian, then read back with a 3-cycle wait each.
    add(1, 0, 24'h0, 8'h00, 8'h00);
    add(1, 0, 24'h1, 8'hA1, 8'h00);
    add(1, 0, 24'h2, 8'h00, 8'h00);
    add(1, 0, 24'h3, 8'h93, 8'h00);
    add(0, 1, 24'h0, 8'h00, 8'h00); idle(8'h00); idle(8'h00); idle(8'h00);
    add(0, 1, 24'h1, 8'h00, 8'h00); idle(8'hA1); idle(8'hA1); idle(8'hA1);
    add(0, 1, 24'h2, 8'h00, 8'hA1); idle(8'h00); idle(8'h00); idle(8'h00);
    add(0, 1, 24'h3, 8'h00, 8'h00); idle(8'h93); idle(8'h93); idle(8'h93);
    // Never-written byte reads erased.
    add(0, 1, 24'h10, 8'h00, 8'h93); idle(8'hFF);
    // Fully pipelined reads, one result per cycle.
    add(0, 1, 24'h0, 8'h00, 8'hFF);
    add(0, 1, 24'h1, 8'h00, 8'h00);
    add(0, 1, 24'h2, 8'h00, 8'hA1);
    add(0, 1, 24'h3, 8'h00, 8'h00);
    idle(8'h93); idle(8'h93);
    // we and re together: write wins, out holds.
    add(1, 1, 24'h5, 8'h3C, 8'h93); idle(8'h93); idle(8'h93);
    add(0, 1, 24'h5, 8'h00, 8'h93); idle(8'h3C);
    add(0, 1, 24'h10, 8'h00, 8'h3C); idle(8'hFF);
    // Aliased address 0x001005 maps to 5.
    add(0, 1, 24'h001005, 8'h00, 8'hFF); idle(8'h3C);
    // Read the cycle after a write to the same address.
    add(1, 0, 24'h6, 8'h5A, 8'h3C);
    add(0, 1, 24'h6, 8'h00, 8'h3C); idle(8'h5A);

    repeat (2) @(posedge clk);
    #1;
    check("reset_out", out, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].din);
      check($sformatf("vec%0d", i), out, vecs[i].exp);
    end

    // Assemble the big-endian word from back-to-back reads.
    word = '0;
    step(0, 1, 24'h0, 8'h00);
    for (int i = 1; i < 4; i++) begin
      step(0, 1, 24'(i), 8'h00);
      word = {word[23:0], out};
    end
    step(0, 0, 24'h0, 8'h00);
    word = {word[23:0], out};
    check("word", word, 32'h00A10093);

    // Reset during a pending read discards it.
    step(0, 1, 24'h1, 8'h00);
    @(negedge clk);
    reset = 1'b1; re = 1'b0;
    @(posedge clk);
    #1;
    check("reset_mid_read", out, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 24'h0, 8'h00);
    check("pending_dropped", out, 8'h00);
    step(0, 1, 24'h3, 8'h00);
    step(0, 0, 24'h0, 8'h00);
    check("after_reset_3", out, 8'h93);
    step(0, 1, 24'h5, 8'h00);
    step(0, 0, 24'h0, 8'h00);
    check("after_reset_5", out, 8'h3C);

`ifdef FLASH_ERASE_EN
    // NOR programming only clears bits.
    step(1, 0, 24'h20, 8'hF0);
    step(1, 0, 24'h20, 8'h3F);
    step(1, 0, 24'h100, 8'h77);
    step(0, 1, 24'h20, 8'h00);
    step(0, 0, 24'h0, 8'h00);
    check("nor_prog", out, 8'h30);
    check("busy_idle", busy, 1'b0);

    @(negedge clk);
    erase = 1'b1; addr = 24'h0;
    @(posedge clk);
    #1;
    @(negedge clk);
    erase = 1'b0;
    @(posedge clk);
    #1;
    n = 1;
    while (busy && n < 300) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("busy_cycles", n, 256);
    step(0, 1, 24'h0, 8'h00);
    step(0, 0, 24'h0, 8'h00);
    check("erased_0", out, 8'hFF);
    step(0, 1, 24'h100, 8'h00);
    step(0, 0, 24'h0, 8'h00);
    check("page1_kept", out, 8'h77);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
